memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-requester arbiter and sequencer in front of the processor's single-port 16 KB memory (32-bit words, combinational read, write on clock edge). Shares the memory between the instruction-fetch port (read-only) and the load/store data port (read/write). Each transaction is latched on grant, performed in one access cycle, and acknowledged with a registered one-cycle `rvalid` pulse. The core's fetch and load/store units connect directly to this block instead of to the memory.

## Interface
Parameters:
- `ADDR_W`, 32: address width passed through to memory.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched word.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse; load data valid or store done.
- `d_rdata`  out  DATA_W  loaded word.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_data_in`  out  DATA_W  to memory `data_in`.
- `mem_we`  out  1  to memory `we`.
- `mem_data_out`  in  DATA_W  from memory `data_out`.

## Operation
- FSM with two states: IDLE and ACCESS.
- IDLE: when any `*_req` is high, pick one winner. Assert that port's `*_gnt` combinationally in the same cycle. Latch address, `we` (forced 0 for fetch), wdata and port id. Go to ACCESS.
- ACCESS: drive `mem_address`/`mem_data_in` from latched registers. Set `mem_we` = latched we. On the next edge, capture `mem_data_out` into the winner's `*_rdata` (loads and fetches only), set the winner's `*_rvalid` for one cycle, and return to IDLE. No grants are issued in ACCESS.
- Arbitration with no contention: the single requester wins.
- Arbitration on contention: data port wins (fixed priority), unless the macro in Configuration is enabled.
- `*_rdata` holds its value until the next read response to that port. Stores do not change `d_rdata`; `d_rvalid` still pulses as the completion ack.
- Outside ACCESS: `mem_we` = 0, `mem_address` = latched address.
- No alignment checking. The memory uses `address[13:2]`.
- Requesters must not issue a new request before the previous `*_rvalid`. Behaviour on violation is undefined.

## Timing
- Request granted in cycle T (IDLE). Memory access in T+1. `*_rvalid` high in T+2.
- T+2 is IDLE, so a new grant may occur there. Peak throughput: one transaction per 2 cycles.
- A store is written to memory at the rising edge that ends T+1.
- Reset values: state IDLE, all `*_gnt`/`*_rvalid` = 0, `mem_we` = 0, `*_rdata` = 0, latched registers = 0, last-winner = fetch.
- `mem_we` is gated by `!reset`. An ACCESS cycle during which `reset` is high writes nothing, produces no `rvalid`, and goes to IDLE.
- A request deasserted before grant is simply never granted. No state is kept for it.

## Configuration
- `MEMORY_ARBITER_RR_EN` defined: round-robin on contention. The port not granted most recently wins. A last-winner register updates on every grant.
- `MEMORY_ARBITER_RR_EN` undefined: fixed priority, data over fetch. The last-winner register is not built.
- The uncontended path and all timing are identical in both modes. The first contention after reset goes to data in both modes.

## Structure
- Package `memory_arbiter_pkg`: state enum (`ST_IDLE`, `ST_ACCESS`), port-id constants (`PORT_IF` = 0, `PORT_D` = 1), default widths.
- One sub-module, `arb2_select`: combinational 2-way picker. Inputs: `req[1:0]`, `last_winner`. Outputs: `grant[1:0]`, `winner_id`. The macro selects round-robin or fixed priority inside it.

## Test plan
- Fetch only: memory word 0x40 holds 0x00500093; `if_req`, `if_addr`=0x100 at T -> `if_gnt` at T, `mem_address`=0x100 at T+1, `if_rvalid`=1 and `if_rdata`=0x00500093 at T+2.
- Store then load: `d_we`=1, `d_addr`=0x800, `d_wdata`=0xDEADBEEF -> memory word 512 = 0xDEADBEEF after T+1, `d_rvalid` at T+2. Then a load of 0x800 -> `d_rdata`=0xDEADBEEF.
- Contention, macro off: both ports request continuously for 3 transactions -> data granted every time, fetch never.
- Contention, macro on: both ports request continuously -> grants alternate D, IF, D, IF with `rvalid` pulses 2 cycles after each grant.
- Reset during a store's ACCESS cycle: memory word unchanged, no `d_rvalid`, FSM in IDLE, all outputs at reset values the next cycle.
- Back-to-back: fetch granted at T, data already requesting -> data granted at T+2, in the same cycle as `if_rvalid`.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared types and constants for the two-port memory arbiter.
//   state_e    : sequencer states (ST_IDLE, ST_ACCESS)
//   PORT_IF    : port id of the instruction-fetch requester (0)
//   PORT_D     : port id of the load/store requester (1)
//   DEF_*_W    : default address / data widths
// Optional feature macro: MEMORY_ARBITER_RR_EN (round-robin on contention).
package memory_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // The requester that is not 'p'; used to rotate priority.
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

  // One-hot grant vector (bit index = port id) for a given winner.
  function automatic logic [1:0] onehot_port(input logic p);
    return (p == PORT_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// arb2_select
// Combinational two-way picker used by memory_arbiter.
// Ports:
//   req[1:0]    in  active requests, bit index = port id (PORT_IF / PORT_D)
//   last_winner in  port granted most recently (only consulted in round-robin)
//   grant[1:0]  out one-hot grant, zero when nothing requests
//   winner_id   out port id of the winner (PORT_IF when nothing requests)
// Optional feature macro: MEMORY_ARBITER_RR_EN
//   defined   : on contention the port not granted most recently wins
//   undefined : on contention the data port always wins
module arb2_select
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] grant,
  output logic       winner_id
);

  // Pick a single winner among the active requests.
  always_comb begin
    grant     = 2'b00;
    winner_id = PORT_IF;
    case (req)
      2'b01: begin
        winner_id = PORT_IF;
        grant     = onehot_port(PORT_IF);
      end
      2'b10: begin
        winner_id = PORT_D;
        grant     = onehot_port(PORT_D);
      end
      2'b11: begin
`ifdef MEMORY_ARBITER_RR_EN
        winner_id = other_port(last_winner);
`else
        winner_id = PORT_D;
`endif
        grant = onehot_port(winner_id);
      end
      default: begin
        winner_id = PORT_IF;
        grant     = 2'b00;
      end
    endcase
  end

`ifndef MEMORY_ARBITER_RR_EN
  // Fixed priority ignores history; keep the input visibly consumed.
  logic unused_last_winner_s;
  assign unused_last_winner_s = last_winner;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-port memory (combinational read, write on clock edge)
// between the instruction-fetch port (read-only) and the load/store port.
// A request is granted combinationally in IDLE, latched, performed in the
// following ACCESS cycle, and acknowledged by a registered one-cycle rvalid.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt                     fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata         fetch response pulse / fetched word (held)
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_gnt)
//   d_gnt                      data request accepted this cycle
//   d_rvalid/d_rdata           load data / store completion pulse, load word
//   mem_address/mem_data_in    to memory, driven from the latched request
//   mem_we                     to memory, high only in a store's ACCESS cycle
//   mem_data_out               from memory
// Optional feature macro: MEMORY_ARBITER_RR_EN (round-robin on contention,
// builds the last-winner register). Default build: data over fetch.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e             state_r;
  state_e             state_next_s;
  logic               accept_s;
  logic [1:0]         req_s;
  logic [1:0]         grant_s;
  logic               winner_s;
  logic               last_winner_s;

  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               we_r;
  logic               port_r;
  logic [DATA_W-1:0]  if_rdata_r;
  logic [DATA_W-1:0]  d_rdata_r;
  logic               if_rvalid_r;
  logic               d_rvalid_r;

  assign req_s = {d_req, if_req};

  arb2_select u_select (
    .req         (req_s),
    .last_winner (last_winner_s),
    .grant       (grant_s),
    .winner_id   (winner_s)
  );

`ifdef MEMORY_ARBITER_RR_EN
  logic last_winner_r;

  // Remember which port received the most recent grant (fetch after reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_r <= PORT_IF;
    end else if (accept_s) begin
      last_winner_r <= winner_s;
    end
  end

  assign last_winner_s = last_winner_r;
`else
  assign last_winner_s = PORT_IF;
`endif

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and grant acceptance; grants only from IDLE and never while
  // reset is asserted, since reset would discard the latched request anyway.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((req_s != 2'b00) && !reset) begin
          accept_s     = 1'b1;
          state_next_s = ST_ACCESS;
        end else begin
          accept_s     = 1'b0;
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign if_gnt = accept_s & grant_s[PORT_IF];
  assign d_gnt  = accept_s & grant_s[PORT_D];

  // Latch the winning request on grant; respond at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      we_r        <= 1'b0;
      port_r      <= PORT_IF;
      if_rdata_r  <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
    end else begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if (accept_s) begin
        port_r <= winner_s;
        if (winner_s == PORT_D) begin
          addr_r  <= d_addr;
          we_r    <= d_we;
          wdata_r <= d_wdata;
        end else begin
          // Fetch port is read-only: never carry a write enable or data.
          addr_r  <= if_addr;
          we_r    <= 1'b0;
          wdata_r <= {DATA_W{1'b0}};
        end
      end else if (state_r == ST_ACCESS) begin
        if (port_r == PORT_IF) begin
          if_rvalid_r <= 1'b1;
          if_rdata_r  <= mem_data_out;
        end else begin
          d_rvalid_r <= 1'b1;
          // A store only acknowledges; the last loaded word is kept.
          if (!we_r) begin
            d_rdata_r <= mem_data_out;
          end
        end
      end
    end
  end

  assign mem_address = addr_r;
  assign mem_data_in = wdata_r;
  // Reset in an ACCESS cycle must suppress the pending write.
  assign mem_we      = (state_r == ST_ACCESS) & we_r & ~reset;

  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// Testbench for memory_arbiter: directed steps from the test plan followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_we;
  logic [DW-1:0] mem_data_out;

  // Memory preload port (testbench only).
  logic          pre_we;
  logic [11:0]   pre_idx;
  logic [31:0]   pre_data;

  logic [31:0]   mem     [0:4095];
  logic [31:0]   ref_mem [0:4095];

  int checks;
  int errors;
  int cyc;

  // Reference model: one outstanding transaction, timed from its grant cycle.
  int          last_gnt;
  logic        pv;
  logic        pport;
  logic        pwe;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] pread;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] exp_lat;
  logic        rr_last;
  int          if_gnt_cnt;
  int          d_gnt_cnt;
  logic        first_win;
  logic        first_seen;
  logic        g_if;
  logic        g_d;
  int          free_if;
  int          free_d;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16 KB single-port memory: combinational read, write on rising edge.
  assign mem_data_out = mem[mem_address[13:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_address[13:2]] <= mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Check the current cycle at the falling edge, advance the model, then
  // return just after the next rising edge so the caller drives new inputs.
  task automatic do_cycle();
    logic e_irv, e_drv, e_we, e_ig, e_dg, elig, win;
    @(negedge clk);
    e_irv = pv && (cyc == last_gnt + 2) && (pport == PORT_IF);
    e_drv = pv && (cyc == last_gnt + 2) && (pport == PORT_D);
    if (e_irv) exp_if_rdata = pread;
    if (e_drv && !pwe) exp_d_rdata = pread;
    e_we = pv && (cyc == last_gnt + 1) && pwe && !reset;
    elig = !reset && (cyc >= last_gnt + 2);
    e_ig = 1'b0;
    e_dg = 1'b0;
    win  = PORT_IF;
    if (elig && (if_req || d_req)) begin
      if (if_req && d_req) begin
`ifdef MEMORY_ARBITER_RR_EN
        win = ~rr_last;
`else
        win = PORT_D;
`endif
        if (!first_seen) begin
          first_seen = 1'b1;
          first_win  = win;
        end
      end else begin
        win = d_req ? PORT_D : PORT_IF;
      end
      e_ig = (win == PORT_IF);
      e_dg = (win == PORT_D);
    end
    chk1("if_gnt", if_gnt, e_ig);
    chk1("d_gnt", d_gnt, e_dg);
    chk1("if_rvalid", if_rvalid, e_irv);
    chk1("d_rvalid", d_rvalid, e_drv);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk1("mem_we", mem_we, e_we);
    chk("mem_address", mem_address, exp_lat);
    if (e_we) chk("mem_data_in", mem_data_in, pwdata);
    if (e_drv && pwe) chk("store_mem", mem[paddr[13:2]], pwdata);
    if (e_we) ref_mem[paddr[13:2]] = pwdata;
    if (e_irv || e_drv) pv = 1'b0;
    if (e_ig || e_dg) begin
      last_gnt = cyc;
      pv       = 1'b1;
      pport    = win;
      pwe      = (win == PORT_D) ? d_we : 1'b0;
      paddr    = (win == PORT_D) ? d_addr : if_addr;
      pwdata   = (win == PORT_D) ? d_wdata : 32'd0;
      pread    = ref_mem[paddr[13:2]];
      exp_lat  = paddr;
      rr_last  = win;
      if (e_ig) if_gnt_cnt++;
      if (e_dg) d_gnt_cnt++;
    end
    g_if = e_ig;
    g_d  = e_dg;
    if (reset) begin
      pv           = 1'b0;
      last_gnt     = -10;
      exp_lat      = 32'd0;
      exp_if_rdata = 32'd0;
      exp_d_rdata  = 32'd0;
      rr_last      = PORT_IF;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Protocol-abiding requesters: hold until granted, re-request no earlier
  // than the rvalid cycle of the previous transaction.
  task automatic auto_req(input bit always_on);
    logic [31:0] a;
    if (reset) begin
      if_req  = 1'b0;
      d_req   = 1'b0;
      free_if = 0;
      free_d  = 0;
    end else begin
      if (g_if) begin
        if_req  = 1'b0;
        free_if = cyc + 1;
      end else if (!if_req && cyc >= free_if && (always_on || $urandom_range(0, 2) == 0)) begin
        a = $urandom;
        a[13:2] = 12'($urandom_range(0, 63));
        if_req  = 1'b1;
        if_addr = a;
      end
      if (g_d) begin
        d_req  = 1'b0;
        free_d = cyc + 1;
      end else if (!d_req && cyc >= free_d && (always_on || $urandom_range(0, 2) == 0)) begin
        a = $urandom;
        a[13:2] = 12'($urandom_range(0, 63));
        d_req   = 1'b1;
        d_addr  = a;
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
    end
  endtask

  logic [31:0] saved;
  int          cnt_before;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    last_gnt = -10; pv = 1'b0; pport = PORT_IF; pwe = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; pread = 32'd0;
    exp_if_rdata = 32'd0; exp_d_rdata = 32'd0; exp_lat = 32'd0;
    rr_last = PORT_IF; if_gnt_cnt = 0; d_gnt_cnt = 0;
    first_win = PORT_IF; first_seen = 1'b0; g_if = 1'b0; g_d = 1'b0;
    free_if = 0; free_d = 0;
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    pre_we = 1'b0; pre_idx = 12'd0; pre_data = 32'd0;

    // Preload memory under reset; word 0x40 holds the test-plan instruction.
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = 12'(i);
      pre_data = (i == 64) ? 32'h0050_0093 : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    do_cycle();
    do_cycle();
    reset = 1'b0;
    do_cycle();

    // Fetch only.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    do_cycle();
    if_req = 1'b0;
    do_cycle();
    do_cycle();
    chk("fetch_word", if_rdata, 32'h0050_0093);

    // Store then load.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0800; d_wdata = 32'hDEAD_BEEF;
    do_cycle();
    d_req = 1'b0;
    do_cycle();
    chk("store_word", mem[512], 32'hDEAD_BEEF);
    do_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800; d_wdata = 32'd0;
    do_cycle();
    d_req = 1'b0;
    do_cycle();
    do_cycle();
    chk("load_word", d_rdata, 32'hDEAD_BEEF);

    // Back-to-back: data waiting while a fetch is in flight.
    if_req = 1'b1; if_addr = 32'h0000_0104;
    do_cycle();
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
    cnt_before = d_gnt_cnt;
    do_cycle();
    do_cycle();
    chk("b2b_d_gnt", 32'(d_gnt_cnt), 32'(cnt_before + 1));
    d_req = 1'b0;
    do_cycle();
    do_cycle();

    // Request withdrawn before it could be granted.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h1234_5678;
    do_cycle();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0300;
    cnt_before = if_gnt_cnt;
    do_cycle();
    if_req = 1'b0;
    do_cycle();
    do_cycle();
    do_cycle();
    chk("withdrawn_never_granted", 32'(if_gnt_cnt), 32'(cnt_before));

    // Reset during a store's ACCESS cycle.
    saved = ref_mem[256];
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'hCAFE_F00D;
    do_cycle();
    d_req = 1'b0; reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    do_cycle();
    chk("reset_store_mem", mem[256], saved);
    do_cycle();

    // Contention: both ports request continuously.
    if_gnt_cnt = 0; d_gnt_cnt = 0; first_seen = 1'b0;
    free_if = 0; free_d = 0; g_if = 1'b0; g_d = 1'b0;
    for (int i = 0; i < 14; i++) begin
      auto_req(1'b1);
      do_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    do_cycle(); do_cycle(); do_cycle();
    chk1("contention_first_d", first_win, PORT_D);
`ifdef MEMORY_ARBITER_RR_EN
    chk1("contention_if_served", 1'(if_gnt_cnt >= 2), 1'b1);
    chk1("contention_d_served", 1'(d_gnt_cnt >= 2), 1'b1);
`else
    chk("contention_if_never", 32'(if_gnt_cnt), 32'd0);
    chk1("contention_d_3plus", 1'(d_gnt_cnt >= 3), 1'b1);
`endif

    // Randomized traffic with occasional resets.
    free_if = 0; free_d = 0; g_if = 1'b0; g_d = 1'b0;
    for (int i = 0; i < 600; i++) begin
      auto_req(1'b0);
      reset = ($urandom_range(0, 199) == 0);
      do_cycle();
    end
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    do_cycle(); do_cycle(); do_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
